alu_serial_exec: RTL and testbench
==================================

ALU_SERIAL_EXEC -- requirements
Module: alu_serial_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width (log2 XLEN).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  operation request.
REQ-006 SHALL have port o_ready  output  1  block can accept an operation this cycle.
REQ-007 SHALL have port i_alu_ctrl  input  5  operation code from the ALU decoder.
REQ-008 SHALL have port i_src_a  input  XLEN  operand A / value to shift.
REQ-009 SHALL have port i_src_b  input  XLEN  operand B; bits [SHAMT_W-1:0] are the shift amount.
REQ-010 SHALL have port i_flush  input  1  abort in-flight operation.
REQ-011 SHALL have port o_valid  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port o_result  output  XLEN  registered result.
REQ-013 SHALL have port o_branch_taken  output  1  registered branch decision, qualified by o_valid.

Function
REQ-014 Codes SHALL be: AND 00000, OR 00001, XOR 00010, ADD 00011, SUB 00100, SLL 00101, SRL 00110, SLT 00111, SLTU 01000, SRA 01001, BEQ 01010, BNE 01011, BLT 01100, BLTU 01101, BGE 01110, BGEU 01111.
REQ-015 Acceptance SHALL occur on a rising edge where i_valid & o_ready & !i_flush.
REQ-016 FSM SHALL have states IDLE (o_ready=1) and SHIFT (o_ready=0).
REQ-017 Non-shift op or shift with shamt=0 accepted in IDLE SHALL give o_valid=1 in the next cycle and remain IDLE; throughput one op per cycle.
REQ-018 Shift with shamt=s>0 accepted SHALL load accumulator=i_src_a, counter=s, enter SHIFT.
REQ-019 In SHIFT, each edge SHALL shift accumulator one bit (SLL left zero-fill, SRL right zero-fill, SRA right sign-fill) and decrement counter.
REQ-020 Edge where counter goes 1->0 SHALL load o_result with the final shifted value, pulse o_valid, return to IDLE; o_valid thus appears s cycles later than a non-shift op.
REQ-021 Arithmetic SHALL be modulo 2^XLEN, carries discarded; SLT/BLT/BGE signed two's complement, SLTU/BLTU/BGEU unsigned.
REQ-022 SLT/SLTU SHALL yield o_result = {XLEN-1 zeros, compare bit}, o_branch_taken=0.
REQ-023 Branch codes SHALL yield o_branch_taken = condition, o_result = {XLEN-1 zeros, condition}.
REQ-024 Non-branch codes SHALL yield o_branch_taken=0.
REQ-025 Codes 10000-11111 SHALL complete as single-cycle ops with o_result=0, o_branch_taken=0.
REQ-026 Operands and code SHALL be sampled only at acceptance; input changes during SHIFT SHALL have no effect.
REQ-027 i_flush SHALL, at the next edge, force IDLE, clear counter, force o_valid=0, and block any same-cycle acceptance; flush has priority over completion.
REQ-028 o_result and o_branch_taken SHALL hold their last values while o_valid=0.
REQ-029 i_valid in SHIFT SHALL be ignored (o_ready=0); upstream holds it.

Reset
REQ-030 i_rst SHALL asynchronously force IDLE, o_valid=0, o_result=0, o_branch_taken=0, counter=0, accumulator=0.
REQ-031 Reset asserted mid-SHIFT SHALL discard the operation; no o_valid after release.
REQ-032 First acceptance SHALL be possible on the first edge after i_rst deasserts.

Structure
REQ-033 Shared package alu_pkg SHALL hold the 5-bit operation-code constants, the FSM state type and XLEN default; decoder and this block both use it.
REQ-034 Sub-module alu_serial_shifter SHALL hold accumulator, counter and shift direction/fill; top holds FSM, combinational ops and output registers.

Verification
REQ-035 ADD a=0xFFFFFFFF b=0x00000001 -> next cycle o_valid=1, o_result=0x00000000, o_branch_taken=0.
REQ-036 SRA a=0x80000000 b=4 -> o_ready low 4 cycles, o_valid 4 cycles after an ADD would, o_result=0xF8000000.
REQ-037 Back-to-back SUB 5-7 then SLTU 1<0xFFFFFFFF -> consecutive o_valid pulses, results 0xFFFFFFFE then 0x00000001.
REQ-038 BLT a=0xFFFFFFFF b=0x00000001 -> o_branch_taken=1; BLTU same operands -> o_branch_taken=0.
REQ-039 SLL a=1 b=31, i_flush asserted 3 cycles after acceptance -> no o_valid, IDLE, o_result unchanged.
REQ-040 SRL a=0xF0 b=8 with i_rst pulsed mid-SHIFT -> all outputs 0, no o_valid; code 11111 afterwards -> o_valid=1, o_result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state type, default width.
// Imported by the ALU decoder and the serial execute block.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SLTU = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_BNE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BLTU = 5'b01101;
    localparam logic [4:0] OP_BGE  = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_t;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic shift_t shift_kind(input logic [4:0] op);
        case (op)
            OP_SRL:  return SH_SRL;
            OP_SRA:  return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one bit position per clock until the count hits zero.
// Ports: clk/rst, load (capture src/shamt/kind), flush (drop count),
//        acc_next (accumulator after the next step), count (steps left).
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  shift_t             kind_in,
    input  logic [XLEN-1:0]    src,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    acc_next,
    output logic [SHAMT_W-1:0] count
);

    logic [XLEN-1:0] acc;
    shift_t          kind;

    always_comb begin
        acc_next = acc;
        case (kind)
            SH_SLL:  acc_next = {acc[XLEN-2:0], 1'b0};
            SH_SRL:  acc_next = {1'b0, acc[XLEN-1:1]};
            SH_SRA:  acc_next = {acc[XLEN-1], acc[XLEN-1:1]};
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            kind  <= SH_SLL;
        end else if (flush) begin
            count <= '0;
        end else if (load) begin
            acc   <= src;
            count <= shamt;
            kind  <= kind_in;
        end else if (count != '0) begin
            acc   <= acc_next;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_serial_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch, serial shifts.
// Ports: i_valid/o_ready request handshake, i_alu_ctrl/i_src_a/i_src_b
//        operation, i_flush abort, o_valid pulse with o_result/o_branch_taken.
module alu_serial_exec
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_alu_ctrl,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_branch_taken
);

    state_t             state;
    logic               accept;
    logic               long_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] count;
    logic [XLEN-1:0]    acc_next;
    logic [XLEN-1:0]    op_result;
    logic               op_branch;
    logic               eq;
    logic               lt_s;
    logic               lt_u;

    assign o_ready    = (state == ST_IDLE);
    assign shamt      = i_src_b[SHAMT_W-1:0];
    assign accept     = i_valid & o_ready & ~i_flush;
    // Zero-amount shifts finish in the single-cycle path.
    assign long_shift = is_shift(i_alu_ctrl) && (shamt != '0);

    assign eq   = (i_src_a == i_src_b);
    assign lt_s = ($signed(i_src_a) < $signed(i_src_b));
    assign lt_u = (i_src_a < i_src_b);

    always_comb begin
        op_result = '0;
        op_branch = 1'b0;
        case (i_alu_ctrl)
            OP_AND:  op_result = i_src_a & i_src_b;
            OP_OR:   op_result = i_src_a | i_src_b;
            OP_XOR:  op_result = i_src_a ^ i_src_b;
            OP_ADD:  op_result = i_src_a + i_src_b;
            OP_SUB:  op_result = i_src_a - i_src_b;
            OP_SLL:  op_result = i_src_a << shamt;
            OP_SRL:  op_result = i_src_a >> shamt;
            OP_SRA:  op_result = XLEN'($signed(i_src_a) >>> shamt);
            OP_SLT:  op_result = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: op_result = {{(XLEN-1){1'b0}}, lt_u};
            OP_BEQ:  op_branch = eq;
            OP_BNE:  op_branch = ~eq;
            OP_BLT:  op_branch = lt_s;
            OP_BLTU: op_branch = lt_u;
            OP_BGE:  op_branch = ~lt_s;
            OP_BGEU: op_branch = ~lt_u;
            default: op_result = '0;
        endcase
        if (i_alu_ctrl[4:1] inside {4'b0101, 4'b0110, 4'b0111}) begin
            op_result = {{(XLEN-1){1'b0}}, op_branch};
        end
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (accept & long_shift),
        .flush    (i_flush),
        .kind_in  (shift_kind(i_alu_ctrl)),
        .src      (i_src_a),
        .shamt    (shamt),
        .acc_next (acc_next),
        .count    (count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            o_valid        <= 1'b0;
            o_result       <= '0;
            o_branch_taken <= 1'b0;
        end else if (i_flush) begin
            // Flush wins over any completion due on this edge.
            state   <= ST_IDLE;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (long_shift) begin
                            state <= ST_SHIFT;
                        end else begin
                            o_valid        <= 1'b1;
                            o_result       <= op_result;
                            o_branch_taken <= op_branch;
                        end
                    end
                end
                ST_SHIFT: begin
                    // Last step: take the value the shifter is about to hold.
                    if (count == SHAMT_W'(1)) begin
                        state          <= ST_IDLE;
                        o_valid        <= 1'b1;
                        o_result       <= acc_next;
                        o_branch_taken <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_serial_exec;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_alu_ctrl;
    logic [31:0] i_src_a;
    logic [31:0] i_src_b;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_branch_taken;

    int n_cmp = 0;
    int n_bad = 0;

    alu_serial_exec #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_alu_ctrl     (i_alu_ctrl),
        .i_src_a        (i_src_a),
        .i_src_b        (i_src_b),
        .i_flush        (i_flush),
        .o_valid        (o_valid),
        .o_result       (o_result),
        .o_branch_taken (o_branch_taken)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result, branch flag and cycles from acceptance to o_valid.
    function automatic void ref_op(input logic [4:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] r,
                                   output logic br,
                                   output int lat);
        int s;
        s   = int'(b[4:0]);
        r   = 32'h0;
        br  = 1'b0;
        lat = 1;
        case (int'(op))
            0:  r = a & b;
            1:  r = a | b;
            2:  r = a ^ b;
            3:  r = a + b;
            4:  r = a - b;
            5:  begin r = a << s; lat = 1 + s; end
            6:  begin r = a >> s; lat = 1 + s; end
            7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8:  r = (a < b) ? 32'd1 : 32'd0;
            9:  begin r = $signed(a) >>> s; lat = 1 + s; end
            10: br = (a == b);
            11: br = (a != b);
            12: br = ($signed(a) < $signed(b));
            13: br = (a < b);
            14: br = ($signed(a) >= $signed(b));
            15: br = (a >= b);
            default: r = 32'h0;
        endcase
        if (op >= 5'd10 && op <= 5'd15) r = {31'b0, br};
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eb;
        int          el;
        int          lat;
        int          rdy_lo;
        ref_op(op, a, b, er, eb, el);
        @(negedge i_clk);
        check({tag, ".ready"}, 64'(o_ready), 64'd1);
        i_valid    = 1'b1;
        i_alu_ctrl = op;
        i_src_a    = a;
        i_src_b    = b;
        @(negedge i_clk);
        i_valid    = 1'b0;
        i_alu_ctrl = 5'($urandom);
        i_src_a    = $urandom;
        i_src_b    = $urandom;
        lat    = 1;
        rdy_lo = 0;
        while (!o_valid && lat < 48) begin
            if (!o_ready) rdy_lo++;
            // Held request and changing operands must not disturb a shift.
            i_valid = 1'($urandom);
            i_src_a = $urandom;
            i_alu_ctrl = 5'($urandom);
            @(negedge i_clk);
            lat++;
        end
        i_valid = 1'b0;
        check({tag, ".lat"}, 64'(lat), 64'(el));
        check({tag, ".res"}, 64'(o_result), 64'(er));
        check({tag, ".br"}, 64'(o_branch_taken), 64'(eb));
        check({tag, ".rdylo"}, 64'(rdy_lo), 64'(el - 1));
        @(negedge i_clk);
        check({tag, ".pulse"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        int spur;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_flush    = 1'b0;
        i_alu_ctrl = 5'd0;
        i_src_a    = 32'd0;
        i_src_b    = 32'd0;
        repeat (2) @(negedge i_clk);
        check("rst.valid", 64'(o_valid), 64'd0);
        check("rst.res", 64'(o_result), 64'd0);
        check("rst.br", 64'(o_branch_taken), 64'd0);
        check("rst.ready", 64'(o_ready), 64'd1);
        i_rst = 1'b0;

        run_op("add_wrap", 5'd3, 32'hFFFF_FFFF, 32'd1);
        run_op("sra4", 5'd9, 32'h8000_0000, 32'd4);

        // Back-to-back SUB then SLTU.
        @(negedge i_clk);
        i_valid = 1'b1; i_alu_ctrl = 5'd4; i_src_a = 32'd5; i_src_b = 32'd7;
        @(negedge i_clk);
        check("b2b.sub.v", 64'(o_valid), 64'd1);
        check("b2b.sub.r", 64'(o_result), 64'hFFFF_FFFE);
        i_alu_ctrl = 5'd8; i_src_a = 32'd1; i_src_b = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("b2b.sltu.v", 64'(o_valid), 64'd1);
        check("b2b.sltu.r", 64'(o_result), 64'd1);
        check("b2b.sltu.br", 64'(o_branch_taken), 64'd0);

        run_op("blt", 5'd12, 32'hFFFF_FFFF, 32'd1);
        run_op("bltu", 5'd13, 32'hFFFF_FFFF, 32'd1);

        // Flush three cycles into SLL 1<<31.
        run_op("pre", 5'd3, 32'd5, 32'd5);
        @(negedge i_clk);
        i_valid = 1'b1; i_alu_ctrl = 5'd5; i_src_a = 32'd1; i_src_b = 32'd31;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush.valid", 64'(o_valid), 64'd0);
        check("flush.ready", 64'(o_ready), 64'd1);
        check("flush.res", 64'(o_result), 64'd10);
        spur = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) spur++;
        end
        check("flush.spur", 64'(spur), 64'd0);

        // Flush blocks a same-cycle request in IDLE.
        i_flush = 1'b1; i_valid = 1'b1;
        i_alu_ctrl = 5'd3; i_src_a = 32'd1; i_src_b = 32'd1;
        @(negedge i_clk);
        i_flush = 1'b0; i_valid = 1'b0;
        check("flblk.valid", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        check("flblk.valid2", 64'(o_valid), 64'd0);
        check("flblk.res", 64'(o_result), 64'd10);

        // Reset in the middle of SRL 0xF0 >> 8.
        @(negedge i_clk);
        i_valid = 1'b1; i_alu_ctrl = 5'd6; i_src_a = 32'hF0; i_src_b = 32'd8;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("rmid.valid", 64'(o_valid), 64'd0);
        check("rmid.res", 64'(o_result), 64'd0);
        check("rmid.br", 64'(o_branch_taken), 64'd0);
        check("rmid.ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        spur = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_valid) spur++;
        end
        check("rmid.spur", 64'(spur), 64'd0);

        // Acceptance on the first edge after reset release.
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_valid = 1'b1; i_alu_ctrl = 5'd3; i_src_a = 32'd2; i_src_b = 32'd3;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("first.valid", 64'(o_valid), 64'd1);
        check("first.res", 64'(o_result), 64'd5);
        run_op("inval", 5'b11111, 32'h1234_5678, 32'h9ABC_DEF0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) op = 5'($urandom_range(0, 15));
            else op = 5'($urandom_range(16, 31));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            run_op("rand", op, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
